// File: rtl/acc_profile_sequencer.sv
// rtl/acc_profile_sequencer.sv - two-slot descriptor sequencer driving an acceleration profile generator
// Purpose: accepts motion-segment descriptors, loads each into the profile
//   generator, paces acc_step ticks and counts segments; supports abort.
// Ports:
//   clk, reset (async active-low)
//   desc_valid/desc_ready handshake; desc_a/j/jj/target_v/use_target/len payload
//   step_period (tick divider), abort_a_val, cmd_abort
//   pg_* : load/set strobes, acc_step, abort, values; pg_stopped from generator
//   busy, seg_done (pulse), underrun (sticky), seg_count
// Optional feature macro: ACC_SEQ_UNDERRUN_ABORT_EN (underrun enters ABORT
//   instead of IDLE).
module acc_profile_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_a,
    input  logic [31:0] desc_j,
    input  logic [31:0] desc_jj,
    input  logic [31:0] desc_target_v,
    input  logic        desc_use_target,
    input  logic [31:0] desc_len,
    input  logic [15:0] step_period,
    input  logic [31:0] abort_a_val,
    input  logic        cmd_abort,
    output logic        pg_load,
    output logic        pg_set_a,
    output logic        pg_set_j,
    output logic        pg_set_jj,
    output logic        pg_set_target_v,
    output logic        pg_acc_step,
    output logic        pg_abort,
    output logic [31:0] pg_a_val,
    output logic [31:0] pg_j_val,
    output logic [31:0] pg_jj_val,
    output logic [31:0] pg_target_v_val,
    output logic [31:0] pg_abort_a_val,
    input  logic        pg_stopped,
    output logic        busy,
    output logic        seg_done,
    output logic        underrun,
    output logic [15:0] seg_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ABORT} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] j;
        logic [31:0] jj;
        logic [31:0] tv;
        logic        use_t;
        logic [31:0] len;
    } desc_t;

    state_t      state, state_next;
    desc_t       act, pend, incoming;
    logic        pend_valid;
    logic        rst_done;
    logic [15:0] tick;
    logic [31:0] step_cnt;

    logic        accept, abort_now, seg_end, avail, take_next;

    assign incoming = '{a: desc_a, j: desc_j, jj: desc_jj, tv: desc_target_v,
                        use_t: desc_use_target, len: desc_len};

    // rst_done holds desc_ready low until the first clock after reset release.
    assign desc_ready     = rst_done && !pend_valid && (state != ABORT);
    assign accept         = desc_valid && desc_ready;
    assign avail          = pend_valid || accept;
    assign abort_now      = cmd_abort && (state != ABORT);
    assign pg_acc_step    = ((state == RUN) || (state == ABORT)) && (tick == step_period);
    assign pg_abort_a_val = abort_a_val;
    assign busy           = (state != IDLE) || pend_valid;

    // A zero-length descriptor finishes in its LOAD cycle.
    assign seg_end = !abort_now &&
                     (((state == RUN) && pg_acc_step && ((step_cnt + 32'd1) == act.len)) ||
                      ((state == LOAD) && (act.len == 32'd0)));

    assign take_next = (state_next == LOAD) && (state != LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        pg_load         = 1'b0;
        pg_set_a        = 1'b0;
        pg_set_j        = 1'b0;
        pg_set_jj       = 1'b0;
        pg_set_target_v = 1'b0;
        pg_abort        = 1'b0;
        pg_a_val        = 32'd0;
        pg_j_val        = 32'd0;
        pg_jj_val       = 32'd0;
        pg_target_v_val = 32'd0;
        if (abort_now) begin
            state_next = ABORT;
        end else if (seg_end) begin
            if (avail) state_next = LOAD;
`ifdef ACC_SEQ_UNDERRUN_ABORT_EN
            else if (!pg_stopped) state_next = ABORT;
`endif
            else state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (avail) state_next = LOAD;
                LOAD:    state_next = RUN;
                RUN:     state_next = RUN;
                ABORT:   if (pg_stopped && !pg_acc_step) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        if (state == LOAD) begin
            pg_load         = 1'b1;
            pg_set_a        = 1'b1;
            pg_set_j        = 1'b1;
            pg_set_jj       = 1'b1;
            pg_set_target_v = act.use_t;
            pg_a_val        = act.a;
            pg_j_val        = act.j;
            pg_jj_val       = act.jj;
            pg_target_v_val = act.tv;
        end
        if (state == ABORT) pg_abort = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done   <= 1'b0;
            act        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            tick       <= 16'd0;
            step_cnt   <= 32'd0;
            seg_done   <= 1'b0;
            underrun   <= 1'b0;
            seg_count  <= 16'd0;
        end else begin
            rst_done <= 1'b1;
            seg_done <= seg_end;
            if (seg_end) seg_count <= seg_count + 16'd1;
            if (seg_end && !avail && !pg_stopped) underrun <= 1'b1;

            if (abort_now) begin
                act        <= '0;
                pend       <= '0;
                pend_valid <= 1'b0;
            end else if (take_next) begin
                // Pending is oldest; when it is full desc_ready is low,
                // so a drain never coincides with an accept.
                if (pend_valid) begin
                    act        <= pend;
                    pend_valid <= 1'b0;
                end else begin
                    act <= incoming;
                end
            end else if (accept) begin
                pend       <= incoming;
                pend_valid <= 1'b1;
            end

            if (state_next != state)             tick <= 16'd0;
            else if (pg_acc_step)                tick <= 16'd0;
            else if (state == RUN || state == ABORT) tick <= tick + 16'd1;
            else                                 tick <= 16'd0;

            if (state == LOAD)                   step_cnt <= 32'd0;
            else if (state == RUN && pg_acc_step) step_cnt <= step_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_acc_profile_sequencer.sv
// tb/tb_acc_profile_sequencer.sv - directed self-checking bench for acc_profile_sequencer
module tb_acc_profile_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_a, desc_j, desc_jj, desc_target_v, desc_len;
    logic        desc_use_target;
    logic [15:0] step_period;
    logic [31:0] abort_a_val;
    logic        cmd_abort;
    logic        pg_load, pg_set_a, pg_set_j, pg_set_jj, pg_set_target_v, pg_acc_step, pg_abort;
    logic [31:0] pg_a_val, pg_j_val, pg_jj_val, pg_target_v_val, pg_abort_a_val;
    logic        pg_stopped;
    logic        busy, seg_done, underrun;
    logic [15:0] seg_count;

    int vectors = 0;
    int errors  = 0;

    acc_profile_sequencer dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_a(desc_a), .desc_j(desc_j), .desc_jj(desc_jj), .desc_target_v(desc_target_v),
        .desc_use_target(desc_use_target), .desc_len(desc_len),
        .step_period(step_period), .abort_a_val(abort_a_val), .cmd_abort(cmd_abort),
        .pg_load(pg_load), .pg_set_a(pg_set_a), .pg_set_j(pg_set_j), .pg_set_jj(pg_set_jj),
        .pg_set_target_v(pg_set_target_v), .pg_acc_step(pg_acc_step), .pg_abort(pg_abort),
        .pg_a_val(pg_a_val), .pg_j_val(pg_j_val), .pg_jj_val(pg_jj_val),
        .pg_target_v_val(pg_target_v_val), .pg_abort_a_val(pg_abort_a_val),
        .pg_stopped(pg_stopped),
        .busy(busy), .seg_done(seg_done), .underrun(underrun), .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input logic [31:0] a, input logic [31:0] tv, input logic ut,
                            input logic [31:0] len);
        desc_a = a; desc_j = 32'h7; desc_jj = 32'h3;
        desc_target_v = tv; desc_use_target = ut; desc_len = len;
    endtask

    logic [31:0] m_step, m_done, m_load;
    logic        conflict, ready_bad, exp_ab;
    logic [31:0] a_at3;
    int          n_ab, n_st;

    initial begin
        reset = 1'b0; desc_valid = 1'b0; cmd_abort = 1'b0; pg_stopped = 1'b1;
        step_period = 16'd3; abort_a_val = 32'h40;
        set_desc(32'h0, 32'h0, 1'b0, 32'd0);
        step(); step();

        // Reset state
        chk("rst_desc_ready", {31'd0, desc_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pg_outs", {25'd0, pg_load, pg_set_a, pg_set_j, pg_set_jj,
                            pg_set_target_v, pg_acc_step, pg_abort}, 32'd0);
        chk("rst_abort_val", pg_abort_a_val, 32'h40);
        chk("rst_seg_count", {16'd0, seg_count}, 32'd0);
        reset = 1'b1;
        #1 chk("rel_ready_low", {31'd0, desc_ready}, 32'd0);
        step();
        chk("rel_ready_high", {31'd0, desc_ready}, 32'd1);

        // Single segment, step_period=3, len=4
        set_desc(32'h100, 32'h0, 1'b0, 32'd4);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t1_load", {31'd0, pg_load}, 32'd1);
        chk("t1_a_val", pg_a_val, 32'h100);
        chk("t1_sets", {28'd0, pg_set_a, pg_set_j, pg_set_jj, pg_set_target_v}, 32'he);
        chk("t1_load_step", {31'd0, pg_acc_step}, 32'd0);
        m_step = 0; m_done = 0; conflict = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pg_acc_step) m_step[k] = 1'b1;
            if (seg_done) m_done[k] = 1'b1;
            if (pg_load && pg_acc_step) conflict = 1'b1;
        end
        chk("t1_step_mask", m_step, 32'h0001_1110);
        chk("t1_done_mask", m_done, 32'h0002_0000);
        chk("t1_no_conflict", {31'd0, conflict}, 32'd0);
        chk("t1_seg_count", {16'd0, seg_count}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // Back-to-back, step_period=0, len=2 each
        step_period = 16'd0;
        set_desc(32'h111, 32'h0, 1'b0, 32'd2);
        desc_valid = 1'b1;
        step();
        m_step = 0; m_done = 0; m_load = 0; conflict = 0; a_at3 = 0;
        for (int k = 0; k <= 10; k++) begin
            if (pg_acc_step) m_step[k] = 1'b1;
            if (seg_done) m_done[k] = 1'b1;
            if (pg_load) m_load[k] = 1'b1;
            if (pg_load && pg_acc_step) conflict = 1'b1;
            if (k == 3) a_at3 = pg_a_val;
            if (k == 0) set_desc(32'h222, 32'h0, 1'b0, 32'd2);
            if (k == 1) desc_valid = 1'b0;
            step();
        end
        chk("t2_load_mask", m_load, 32'h09);
        chk("t2_step_mask", m_step, 32'h36);
        chk("t2_done_mask", m_done, 32'h48);
        chk("t2_second_a", a_at3, 32'h222);
        chk("t2_no_conflict", {31'd0, conflict}, 32'd0);
        chk("t2_seg_count", {16'd0, seg_count}, 32'd3);

        // Zero-length descriptor with target velocity
        set_desc(32'h0, 32'h500, 1'b1, 32'd0);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t3_load", {31'd0, pg_load}, 32'd1);
        chk("t3_set_tv", {31'd0, pg_set_target_v}, 32'd1);
        chk("t3_tv_val", pg_target_v_val, 32'h500);
        step();
        chk("t3_seg_done", {31'd0, seg_done}, 32'd1);
        chk("t3_no_step", {31'd0, pg_acc_step}, 32'd0);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        chk("t3_seg_count", {16'd0, seg_count}, 32'd4);

        // Abort mid-RUN with a pending descriptor
        step_period = 16'd1; pg_stopped = 1'b0;
        set_desc(32'h10, 32'h0, 1'b0, 32'd100);
        desc_valid = 1'b1;
        step();                        // k=0 LOAD; next desc accepted into pending
        set_desc(32'h20, 32'h0, 1'b0, 32'd100);
        step();
        desc_valid = 1'b0;
        step(); step(); step();        // k=4
        chk("t4_pending_ready", {31'd0, desc_ready}, 32'd0);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("t4_abort_val", pg_abort_a_val, 32'h40);
        n_ab = 0; n_st = 0; ready_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!pg_abort) break;
            n_ab++;
            if (pg_acc_step) n_st++;
            if (desc_ready) ready_bad = 1'b1;
            cmd_abort = (n_ab == 3);
            if (n_st == 5) pg_stopped = 1'b1;
            step();
        end
        cmd_abort = 1'b0;
        chk("t4_abort_cycles", n_ab, 32'd11);
        chk("t4_abort_steps", n_st, 32'd5);
        chk("t4_ready_low", {31'd0, ready_bad}, 32'd0);
        chk("t4_abort_off", {31'd0, pg_abort}, 32'd0);
        chk("t4_flushed", {31'd0, busy}, 32'd0);
        chk("t4_seg_count", {16'd0, seg_count}, 32'd4);

        // Underrun: segment ends with nothing pending and generator still moving
        step_period = 16'd0; pg_stopped = 1'b0;
        set_desc(32'h30, 32'h0, 1'b0, 32'd1);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t5_no_underrun_yet", {31'd0, underrun}, 32'd0);
        step(); step();
`ifdef ACC_SEQ_UNDERRUN_ABORT_EN
        exp_ab = 1'b1;
`else
        exp_ab = 1'b0;
`endif
        chk("t5_underrun", {31'd0, underrun}, 32'd1);
        chk("t5_pg_abort", {31'd0, pg_abort}, {31'd0, exp_ab});
        chk("t5_busy", {31'd0, busy}, {31'd0, exp_ab});
        chk("t5_seg_count", {16'd0, seg_count}, 32'd5);
        pg_stopped = 1'b1;
        step(); step(); step();
        chk("t5_settled", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-RUN
        set_desc(32'h40, 32'h0, 1'b0, 32'd100);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        step(); step();
        chk("t6_running", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        chk("t6_async_outs", {25'd0, pg_load, pg_acc_step, pg_abort, seg_done,
                              underrun, desc_ready, pg_set_a}, 32'd0);
        chk("t6_async_count", {16'd0, seg_count}, 32'd0);
        chk("t6_abort_val", pg_abort_a_val, 32'h40);
        step();
        reset = 1'b1;
        #1 chk("t6_ready_low", {31'd0, desc_ready}, 32'd0);
        step();
        chk("t6_ready_high", {31'd0, desc_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/acc_profile_sequencer.md
ACC_PROFILE_SEQUENCER -- requirements
Module: acc_profile_sequencer

Interface
REQ-001 SHALL have ports: clk in 1 (system clock); reset in 1 (asynchronous, active-low).
REQ-002 SHALL have ports: desc_valid in 1, desc_ready out 1 (descriptor handshake; transfer when both high at posedge clk).
REQ-003 SHALL have ports: desc_a, desc_j, desc_jj, desc_target_v in 32 signed each; desc_use_target in 1; desc_len in 32 unsigned (acc_steps in segment).
REQ-004 SHALL have ports: step_period in 16 (tick divider); abort_a_val in 32 signed (abort decel); cmd_abort in 1 (abort pulse).
REQ-005 SHALL have ports: pg_load, pg_set_a, pg_set_j, pg_set_jj, pg_set_target_v, pg_acc_step, pg_abort out 1; pg_a_val, pg_j_val, pg_jj_val, pg_target_v_val, pg_abort_a_val out 32; pg_stopped in 1.
REQ-006 SHALL have ports: busy out 1, seg_done out 1 (pulse), underrun out 1 (sticky), seg_count out 16.

Function
REQ-007 SHALL hold two descriptor slots: active and pending; desc_ready = pending slot empty and state != ABORT.
REQ-008 SHALL implement states IDLE, LOAD, RUN, ABORT.
REQ-009 IDLE: when a descriptor is available (pending, or accepted this cycle), next state LOAD; that descriptor moves to active.
REQ-010 LOAD: one cycle with pg_load=1, pg_set_a=pg_set_j=pg_set_jj=1, pg_set_target_v=desc_use_target, pg_*_val from active slot; pg_acc_step=0 this cycle; next state RUN.
REQ-011 RUN: tick counter starts at 0 on entry, increments each clk; at value step_period it pulses pg_acc_step for one cycle and restarts at 0 (period step_period+1; step_period=0 gives every cycle).
REQ-012 RUN: steps counted; on the cycle the desc_len-th pg_acc_step is issued, seg_done pulses next cycle, seg_count increments (wraps 0xFFFF->0), next state LOAD if pending valid else IDLE.
REQ-013 desc_len=0: LOAD issued, no pg_acc_step, seg_done pulses, state proceeds as end of RUN.
REQ-014 Simultaneous pending-slot drain and new accept in same cycle SHALL not lose or reorder descriptors.
REQ-015 pg_abort_a_val SHALL equal abort_a_val at all times.
REQ-016 cmd_abort in any state: flush both slots, next state ABORT; RUN tick counter restarts at 0.
REQ-017 ABORT: pg_abort=1 continuously; pg_acc_step ticks per REQ-011; exit to IDLE on first cycle pg_stopped=1 observed with no pg_acc_step that cycle; cmd_abort while in ABORT has no further effect.
REQ-018 busy = (state != IDLE) or pending valid.
REQ-019 pg_load and pg_acc_step SHALL never be high in the same cycle.

Reset
REQ-020 Reset low SHALL immediately force: state IDLE, slots empty, tick and step counters 0, all pg_* outputs 0 except pg_abort_a_val, desc_ready 0, busy 0, seg_done 0, underrun 0, seg_count 0.
REQ-021 Reset deassertion mid-segment SHALL restart from IDLE; desc_ready rises on first clk after release.

Configuration
REQ-022 Macro ACC_SEQ_UNDERRUN_ABORT_EN defined: at end of RUN with no pending descriptor and pg_stopped=0, next state ABORT (not IDLE) and underrun sets.
REQ-023 Macro undefined: same condition goes to IDLE, underrun sets, no abort; underrun clears only on reset.

Verification
REQ-024 step_period=3, one desc len=4 a=0x100 -> pg_load 1 cycle, then pg_acc_step at cycles 4,8,12,16 after LOAD, seg_done 1 cycle later, seg_count=1.
REQ-025 Two back-to-back descs len=2, step_period=0 -> second pg_load the cycle after first segment's 2nd step; no gap longer than 1 cycle; seg_count=2.
REQ-026 desc_len=0 with desc_use_target=1, target 0x500 -> pg_load with pg_set_target_v=1, no pg_acc_step, seg_done pulses.
REQ-027 cmd_abort mid-RUN, abort_a_val=0x40, pg_stopped forced 1 after 5 steps -> pg_abort high throughout, desc_ready 0, IDLE after pg_stopped, pending flushed.
REQ-028 Underrun with pg_stopped=0: macro defined -> ABORT entered, underrun=1; undefined -> IDLE, underrun=1, pg_abort stays 0.
REQ-029 Reset low mid-RUN -> all outputs zero same cycle (asynchronous), desc_ready=1 one clk after release.
